// File: rtl/ssub_serial.sv
`default_nettype none
// ============================================================================
// Module   : ssub_serial
// Brief    : Bit-serial subtractor (adata - bdata), LSB first, with start/ready
//            load and done/ack result handshakes. Optional SSUB_SATURATE_EN
//            clamps an underflowing result to zero.
// Revision : 1.0  initial release
// ============================================================================
module ssub_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] adata,
    input  logic [WIDTH-1:0] bdata,
    input  logic             enable,
    output logic             ready,
    output logic             done,
    input  logic             out_ack,
    output logic [WIDTH-1:0] pout,
    output logic             borrow_out
);

    localparam int              c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_res;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_brw;
    logic                 r_bout;
    logic                 w_load;
    logic                 w_step;
    logic                 w_last;
    logic                 w_d;
    logic                 w_brw_next;

    // Single full-subtractor cell working on the current LSBs.
    assign w_d        = r_a[0] ^ r_b[0] ^ r_brw;
    assign w_brw_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        done   = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        w_last = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_load = 1'b1;
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (enable) begin
                    w_step = 1'b1;
                    if (r_cnt == c_last) begin
                        w_last = 1'b1;
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (out_ack) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_brw  <= 1'b0;
            r_bout <= 1'b0;
        end else if (w_load) begin
            r_a    <= adata;
            r_b    <= bdata;
            r_res  <= '0;
            r_cnt  <= '0;
            r_brw  <= 1'b0;
            r_bout <= 1'b0;
        end else if (w_step) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_res  <= {w_d, r_res[WIDTH-1:1]};
            r_cnt  <= r_cnt + c_cnt_w'(1);
            r_brw  <= w_brw_next;
            if (w_last) begin
                r_bout <= w_brw_next;
`ifdef SSUB_SATURATE_EN
                // Underflow floors the unsigned result at zero.
                if (w_brw_next) begin
                    r_res <= '0;
                end
`endif
            end
        end
    end

    assign pout       = r_res;
    assign borrow_out = r_bout;

endmodule
`default_nettype wire
